// File: rtl/crc_sequencer.sv
// crc_sequencer: buffers CRC_INPUT words in a FIFO and serializes them bit by bit
// into the CRC LFSR, tracking message start/finish/abort for CRC_STATUS.
module crc_sequencer #(
    parameter int WORD_SIZE  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic                          ctrl_start,
    input  logic                          ctrl_finish,
    input  logic                          ctrl_clear,
    input  logic                          cfg_msb_first,
    input  logic                          in_valid,
    input  logic [WORD_SIZE-1:0]          in_data,
    output logic                          crc_init,
    output logic                          crc_shift,
    output logic                          crc_bit,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          fifo_full,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(WORD_SIZE);

    typedef enum logic [2:0] {IDLE, INIT, LOAD, SHIFT, DONE} state_t;

    state_t               r_state;
    logic [WORD_SIZE-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [AW:0]          r_count;
    logic [WORD_SIZE-1:0] r_sreg;
    logic [CW-1:0]        r_cnt;
    logic                 r_msb_first, r_finish_pending, r_overflow;
    logic                 w_empty, w_pop, w_push, w_drop, w_start_ok, w_active;

    assign w_empty    = r_count == '0;
    assign w_pop      = r_state == LOAD && !w_empty && !ctrl_clear;
    // A full FIFO still accepts a push when LOAD frees the head slot this cycle.
    assign w_push     = in_valid && !ctrl_clear && (r_count != (AW+1)'(FIFO_DEPTH) || w_pop);
    assign w_drop     = in_valid && !ctrl_clear && !w_push;
    assign w_start_ok = ctrl_start && (r_state == IDLE || r_state == DONE);
    assign w_active   = r_state == INIT || r_state == LOAD || r_state == SHIFT;

    always_ff @(posedge CLK)
        if (w_push) r_mem[r_wr_ptr] <= in_data;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state          <= IDLE;
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
            r_sreg           <= '0;
            r_cnt            <= '0;
            r_msb_first      <= 1'b0;
            r_finish_pending <= 1'b0;
            r_overflow       <= 1'b0;
        end else if (ctrl_clear) begin
            r_state          <= IDLE;
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
            r_cnt            <= '0;
            r_finish_pending <= 1'b0;
            r_overflow       <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            if (w_start_ok) begin
                r_msb_first      <= cfg_msb_first;
                r_overflow       <= 1'b0;
                r_finish_pending <= 1'b0;
            end
            if (w_drop) r_overflow <= 1'b1;
            if (ctrl_finish && w_active) r_finish_pending <= 1'b1;
            case (r_state)
                IDLE, DONE: if (w_start_ok) r_state <= INIT;
                INIT: r_state <= LOAD;
                LOAD:
                    if (!w_empty) begin
                        r_sreg  <= r_mem[r_rd_ptr];
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end else if (r_finish_pending) begin
                        r_finish_pending <= 1'b0;
                        r_state          <= DONE;
                    end
                SHIFT: begin
                    r_sreg <= r_msb_first ? r_sreg << 1 : r_sreg >> 1;
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WORD_SIZE - 1)) r_state <= LOAD;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy       = w_active;
    assign done       = r_state == DONE;
    assign crc_init   = r_state == INIT;
    assign crc_shift  = r_state == SHIFT;
    assign crc_bit    = crc_shift && (r_msb_first ? r_sreg[WORD_SIZE-1] : r_sreg[0]);
    assign fifo_count = r_count;
    assign fifo_full  = r_count == (AW+1)'(FIFO_DEPTH);
    assign overflow   = r_overflow;
endmodule

// File: tb/tb_crc_sequencer.sv
// tb_crc_sequencer: directed table-driven and hand-sequenced checks of crc_sequencer
// (WORD_SIZE=32, FIFO_DEPTH=4).
module tb_crc_sequencer;
    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ctrl_start = 1'b0, ctrl_finish = 1'b0, ctrl_clear = 1'b0;
    logic        cfg_msb_first = 1'b0, in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        crc_init, crc_shift, crc_bit, busy, done, fifo_full, overflow;
    logic [2:0]  fifo_count;

    int n_cmp = 0;
    int n_bad = 0;

    crc_sequencer #(.WORD_SIZE(32), .FIFO_DEPTH(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .ctrl_start(ctrl_start), .ctrl_finish(ctrl_finish), .ctrl_clear(ctrl_clear),
        .cfg_msb_first(cfg_msb_first), .in_valid(in_valid), .in_data(in_data),
        .crc_init(crc_init), .crc_shift(crc_shift), .crc_bit(crc_bit),
        .busy(busy), .done(done), .fifo_count(fifo_count),
        .fifo_full(fifo_full), .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    // inp = {start, finish, clear, msb_first, valid}
    // exp = {init, shift, bit, busy, done, count[2:0], full, overflow}
    typedef struct packed {
        logic [4:0]  inp;
        logic [31:0] d;
        logic [9:0]  exp;
    } vec_t;

    vec_t tab [8];

    task automatic drive(input logic [4:0] inp, input logic [31:0] d);
        {ctrl_start, ctrl_finish, ctrl_clear, cfg_msb_first, in_valid} = inp;
        in_data = d;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        {ctrl_start, ctrl_finish, ctrl_clear, in_valid} = 4'b0000;
    endtask

    task automatic chk(input string n, input logic [9:0] e);
        logic [9:0] a;
        a = {crc_init, crc_shift, crc_bit, busy, done, fifo_count, fifo_full, overflow};
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got init/shift/bit/busy/done/count/full/ovf=%b expected %b", n, a, e);
        end
    endtask

    task automatic shift_word(input string n, input logic [31:0] w, input logic m,
                              input logic [2:0] c, input int from);
        logic b;
        for (int i = from; i < 32; i++) begin
            tick();
            b = m ? w[31-i] : w[i];
            chk($sformatf("%s_bit%0d", n, i), {2'b01, b, 2'b10, c, c == 3'd4, 1'b0});
        end
        tick();
        chk($sformatf("%s_load", n), {5'b00010, c, c == 3'd4, 1'b0});
    endtask

    logic [31:0] ew [5];
    logic [31:0] ea;
    logic [2:0]  ec;

    initial begin
        tab[0] = '{5'b00011, 32'hC3A5_0001, 10'b00000_001_0_0};
        tab[1] = '{5'b00011, 32'h0000_8001, 10'b00000_010_0_0};
        tab[2] = '{5'b00011, 32'hFFFF_0000, 10'b00000_011_0_0};
        tab[3] = '{5'b00011, 32'h1234_5678, 10'b00000_100_1_0};
        tab[4] = '{5'b00011, 32'hDEAD_BEEF, 10'b00000_100_1_1};
        tab[5] = '{5'b10010, 32'h0000_0000, 10'b10010_100_1_0};
        tab[6] = '{5'b00000, 32'h0000_0000, 10'b00010_100_1_0};
        tab[7] = '{5'b00011, 32'h0F0F_F0F1, 10'b01110_100_1_0};

        #3 chk("reset", 10'b0);
        @(negedge CLK) nRST = 1'b1;
        @(negedge CLK);

        // MSB-first single word, then finish from an empty LOAD
        drive(5'b10011, 32'h8000_0001);
        tick(); chk("a_init", 10'b10010_001_0_0);
        tick(); chk("a_load", 10'b00010_001_0_0);
        shift_word("a", 32'h8000_0001, 1'b1, 3'd0, 0);
        drive(5'b01000, 32'h0);
        tick(); chk("a_fin", 10'b00010_000_0_0);
        tick(); chk("a_done", 10'b00001_000_0_0);
        tick(); chk("a_hold", 10'b00001_000_0_0);
        drive(5'b00100, 32'h0);
        tick(); chk("a_clear", 10'b0);

        // LSB-first word with finish given during INIT
        drive(5'b10001, 32'h0000_000F);
        tick(); chk("b_init", 10'b10010_001_0_0);
        drive(5'b01000, 32'h0);
        tick(); chk("b_load", 10'b00010_001_0_0);
        shift_word("b", 32'h0000_000F, 1'b0, 3'd0, 0);
        tick(); chk("b_done", 10'b00001_000_0_0);
        drive(5'b00100, 32'h0);
        tick(); chk("b_clear", 10'b0);

        // Overflow in IDLE, start, and a push while full that LOAD absorbs
        for (int k = 0; k < 8; k++) begin
            drive(tab[k].inp, tab[k].d);
            tick();
            chk($sformatf("vec%0d", k), tab[k].exp);
        end
        shift_word("c0", 32'hC3A5_0001, 1'b1, 3'd4, 1);
        shift_word("c1", 32'h0000_8001, 1'b1, 3'd3, 0);
        shift_word("c2", 32'hFFFF_0000, 1'b1, 3'd2, 0);
        shift_word("c3", 32'h1234_5678, 1'b1, 3'd1, 0);
        shift_word("c4", 32'h0F0F_F0F1, 1'b1, 3'd0, 0);

        // Clear with a simultaneous push on the 10th bit, after an overflow
        ea = 32'hA5A5_0F0F;
        ew[0] = 32'h0000_0001; ew[1] = 32'h0000_0002; ew[2] = 32'h0000_0003;
        ew[3] = 32'h0000_0004; ew[4] = 32'h0000_0005;
        drive(5'b00011, ea);
        tick(); chk("e_load", 10'b00010_001_0_0);
        for (int k = 2; k <= 11; k++) begin
            if (k <= 6) drive(5'b00011, ew[k-2]);
            tick();
            ec = (k <= 5) ? 3'(k - 1) : 3'd4;
            chk($sformatf("e_shift%0d", k - 1), {2'b01, ea[33-k], 2'b10, ec, ec == 3'd4, k >= 6});
        end
        drive(5'b00111, 32'h1111_1111);
        tick(); chk("e_clear", 10'b0);
        tick(); chk("e_idle", 10'b0);

        // Start during SHIFT is ignored; nRST mid-message zeroes everything at once
        drive(5'b10001, 32'h0000_0002);
        tick(); chk("f_init", 10'b10010_001_0_0);
        tick(); chk("f_load", 10'b00010_001_0_0);
        tick(); chk("f_bit0", 10'b01010_000_0_0);
        tick(); chk("f_bit1", 10'b01110_000_0_0);
        drive(5'b10000, 32'h0);
        tick(); chk("f_start_ign", 10'b01010_000_0_0);
        tick(); chk("f_bit3", 10'b01010_000_0_0);
        #2 nRST = 1'b0;
        #1 chk("f_rst_now", 10'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("f_rst_hold%0d", k), 10'b0);
        end
        #2 nRST = 1'b1;
        tick(); chk("f_after", 10'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
